// File: rtl/pipelined_broadcast_tree_if.sv
// Bus bundle for pipelined_broadcast_tree: upstream message and flush
// controls, plus the per-node valid and payload fan-out.
// The reply reduction signals exist only when
// PIPELINED_BROADCAST_TREE_REPLY_EN is defined.
interface pipelined_broadcast_tree_if #(
  parameter int MESSAGE_WIDTH = 16,
  parameter int NODES         = 10
);

  logic                           clear;
  logic                           in_valid;
  logic [MESSAGE_WIDTH-1:0]       in_message;
  logic [NODES-1:0]               out_valids;
  logic [MESSAGE_WIDTH*NODES-1:0] outputs;

`ifdef PIPELINED_BROADCAST_TREE_REPLY_EN
  logic [NODES-1:0]               node_replies;
  logic                           reply_any;
  logic                           reply_all;

  // Controller side.
  modport master (
    output clear, in_valid, in_message, node_replies,
    input  out_valids, outputs, reply_any, reply_all
  );

  // Tree side.
  modport slave (
    input  clear, in_valid, in_message, node_replies,
    output out_valids, outputs, reply_any, reply_all
  );
`else
  // Controller side.
  modport master (
    output clear, in_valid, in_message,
    input  out_valids, outputs
  );

  // Tree side.
  modport slave (
    input  clear, in_valid, in_message,
    output out_valids, outputs
  );
`endif

endinterface

// File: rtl/pipelined_broadcast_tree.sv
// Registered broadcast tree: fans one message out to NODES consumers.
// Every level is a register stage and no register drives more than
// MAX_FANOUT loads, so all nodes see each message on the same cycle,
// exactly LEVELS cycles after it is presented.
//
// Tree shape: the node stage (level LEVELS-1) holds NODES registers. Each
// level above holds ceil(count_below / MAX_FANOUT) registers, so every
// register feeds at most MAX_FANOUT children. The top stage (level 0) has
// at most MAX_FANOUT registers, all loaded straight from the input port;
// this is what keeps the depth at the minimum LEVELS. Every node sits at
// exactly the same depth, so there is no per-node skew.
//
// Optional feature: define PIPELINED_BROADCAST_TREE_REPLY_EN to build a
// mirror OR/AND reduction tree over node_replies with the same shape and
// depth. It is not gated by valid and ignores clear.
module pipelined_broadcast_tree #(
  parameter int MESSAGE_WIDTH = 16,
  parameter int MAX_FANOUT    = 3,
  parameter int NODES         = 10
) (
  input logic                       clock,
  input logic                       reset,
  pipelined_broadcast_tree_if.slave bus
);

  // Smallest L >= 1 with MAX_FANOUT**L >= NODES.
  function automatic int calc_levels();
    int l;
    int p;
    l = 1;
    p = MAX_FANOUT;
    while (p < NODES) begin
      p = p * MAX_FANOUT;
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = calc_levels();

  // Register count at level j, derived bottom-up from the node count.
  function automatic int level_count(input int j);
    int c;
    c = NODES;
    for (int k = LEVELS - 1; k > j; k--) begin
      c = (c + MAX_FANOUT - 1) / MAX_FANOUT;
    end
    return c;
  endfunction

  // Index of the first register of level j in the flattened register array.
  function automatic int level_offset(input int j);
    int s;
    s = 0;
    for (int k = 0; k < j; k++) begin
      s += level_count(k);
    end
    return s;
  endfunction

  localparam int TOTAL      = level_offset(LEVELS);
  localparam int LEAF_OFF   = level_offset(LEVELS - 1);
  localparam int ROOT_COUNT = level_count(0);

  if (MAX_FANOUT < 2 || NODES < 1) begin : g_param_check
    $error("pipelined_broadcast_tree: needs MAX_FANOUT >= 2 and NODES >= 1");
  end

  // ---------------------------------------------------------------------
  // Broadcast tree
  // ---------------------------------------------------------------------
  logic [TOTAL-1:0]         src_valid;
  logic [TOTAL-1:0]         valid_q;
  logic [MESSAGE_WIDTH-1:0] src_msg [TOTAL];
  logic [MESSAGE_WIDTH-1:0] msg_q   [TOTAL];

  // Wire each register to its parent: level 0 reads the input port,
  // register i of level j reads register i/MAX_FANOUT of level j-1.
  for (genvar j = 0; j < LEVELS; j++) begin : g_level
    for (genvar i = 0; i < level_count(j); i++) begin : g_reg
      localparam int SELF = level_offset(j) + i;
      if (j == 0) begin : g_top
        assign src_valid[SELF] = bus.in_valid;
        assign src_msg[SELF]   = bus.in_message;
      end else begin : g_child
        localparam int PARENT = level_offset(j - 1) + i / MAX_FANOUT;
        assign src_valid[SELF] = valid_q[PARENT];
        assign src_msg[SELF]   = msg_q[PARENT];
      end
    end
  end

  // Advance every stage one level per cycle; clear drops all valids,
  // payloads only load behind a valid so nodes hold the last delivery.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: payload registers are reset too, because outputs must read 0
      // immediately on reset; a payload array that only needs to be defined
      // behind its valid would normally be left unreset.
      valid_q <= '0;
      for (int n = 0; n < TOTAL; n++) begin
        msg_q[n] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample its parent's
      // pre-edge value, which is what makes this a pipeline rather than a
      // chain that collapses into one cycle.
      valid_q <= bus.clear ? '0 : src_valid;
      for (int n = 0; n < TOTAL; n++) begin
        if (src_valid[n]) begin
          msg_q[n] <= src_msg[n];
        end
      end
    end
  end

  // Node stage drives the outputs directly; node i owns slice i.
  for (genvar i = 0; i < NODES; i++) begin : g_node
    assign bus.out_valids[i] = valid_q[LEAF_OFF + i];
    assign bus.outputs[i*MESSAGE_WIDTH +: MESSAGE_WIDTH] = msg_q[LEAF_OFF + i];
  end

`ifdef PIPELINED_BROADCAST_TREE_REPLY_EN
  // ---------------------------------------------------------------------
  // Reply reduction tree (mirror of the broadcast tree)
  // ---------------------------------------------------------------------
  logic [TOTAL-1:0] src_any;
  logic [TOTAL-1:0] src_all;
  logic [TOTAL-1:0] any_q;
  logic [TOTAL-1:0] all_q;

  // Node-level registers sample node_replies; each upper register combines
  // the children it feeds in the broadcast direction. Missing children are
  // padded with the identity value of OR (0) and AND (1).
  for (genvar j = 0; j < LEVELS; j++) begin : g_reply_level
    for (genvar i = 0; i < level_count(j); i++) begin : g_reply_reg
      localparam int SELF = level_offset(j) + i;
      if (j == LEVELS - 1) begin : g_leaf
        assign src_any[SELF] = bus.node_replies[i];
        assign src_all[SELF] = bus.node_replies[i];
      end else begin : g_inner
        logic [MAX_FANOUT-1:0] kid_any;
        logic [MAX_FANOUT-1:0] kid_all;
        for (genvar k = 0; k < MAX_FANOUT; k++) begin : g_kid
          localparam int CHILD = i * MAX_FANOUT + k;
          if (CHILD < level_count(j + 1)) begin : g_real
            assign kid_any[k] = any_q[level_offset(j + 1) + CHILD];
            assign kid_all[k] = all_q[level_offset(j + 1) + CHILD];
          end else begin : g_pad
            assign kid_any[k] = 1'b0;
            assign kid_all[k] = 1'b1;
          end
        end
        assign src_any[SELF] = |kid_any;
        assign src_all[SELF] = &kid_all;
      end
    end
  end

  // Move the partial reductions one level toward the top every cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      any_q <= '0;
      all_q <= '0;
    end else begin
      any_q <= src_any;
      all_q <= src_all;
    end
  end

  // The top stage has at most MAX_FANOUT registers; merge them here.
  assign bus.reply_any = |any_q[ROOT_COUNT-1:0];
  assign bus.reply_all = &all_q[ROOT_COUNT-1:0];
`endif

endmodule

// File: tb/tb_pipelined_broadcast_tree.sv
// Directed bench for pipelined_broadcast_tree: latency, streaming, clear,
// asynchronous reset, depth boundaries and (with the macro) reply reduction.
module tb_pipelined_broadcast_tree;

  localparam int MW = 16;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  pipelined_broadcast_tree_if #(.MESSAGE_WIDTH(MW), .NODES(10)) bus10 ();
  pipelined_broadcast_tree_if #(.MESSAGE_WIDTH(MW), .NODES(1))  bus1  ();
  pipelined_broadcast_tree_if #(.MESSAGE_WIDTH(MW), .NODES(9))  bus9  ();
  pipelined_broadcast_tree_if #(.MESSAGE_WIDTH(MW), .NODES(27)) bus27 ();
  pipelined_broadcast_tree_if #(.MESSAGE_WIDTH(MW), .NODES(28)) bus28 ();

  pipelined_broadcast_tree #(.MESSAGE_WIDTH(MW), .MAX_FANOUT(3), .NODES(10))
    dut10 (.clock(clock), .reset(reset), .bus(bus10.slave));
  pipelined_broadcast_tree #(.MESSAGE_WIDTH(MW), .MAX_FANOUT(3), .NODES(1))
    dut1  (.clock(clock), .reset(reset), .bus(bus1.slave));
  pipelined_broadcast_tree #(.MESSAGE_WIDTH(MW), .MAX_FANOUT(3), .NODES(9))
    dut9  (.clock(clock), .reset(reset), .bus(bus9.slave));
  pipelined_broadcast_tree #(.MESSAGE_WIDTH(MW), .MAX_FANOUT(3), .NODES(27))
    dut27 (.clock(clock), .reset(reset), .bus(bus27.slave));
  pipelined_broadcast_tree #(.MESSAGE_WIDTH(MW), .MAX_FANOUT(3), .NODES(28))
    dut28 (.clock(clock), .reset(reset), .bus(bus28.slave));

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit so outputs are sampled off-edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [511:0] rep(input logic [15:0] m, input int n);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      r[i*16 +: 16] = m;
    end
    return r;
  endfunction

  initial begin
    int            first [4];
    int            hits  [4];
    logic [511:0]  seen  [4];
    logic [15:0]   msg_a, msg_b, msg_c;

    reset = 1'b1;
    bus10.clear = 1'b0; bus10.in_valid = 1'b0; bus10.in_message = '0;
    bus1.clear  = 1'b0; bus1.in_valid  = 1'b0; bus1.in_message  = '0;
    bus9.clear  = 1'b0; bus9.in_valid  = 1'b0; bus9.in_message  = '0;
    bus27.clear = 1'b0; bus27.in_valid = 1'b0; bus27.in_message = '0;
    bus28.clear = 1'b0; bus28.in_valid = 1'b0; bus28.in_message = '0;
`ifdef PIPELINED_BROADCAST_TREE_REPLY_EN
    bus10.node_replies = '0; bus1.node_replies  = '0; bus9.node_replies = '0;
    bus27.node_replies = '0; bus28.node_replies = '0;
`endif

    // Reset state.
    #2;
    check("rst_valids", 512'(bus10.out_valids), 512'(0));
    check("rst_outputs", 512'(bus10.outputs), 512'(0));
`ifdef PIPELINED_BROADCAST_TREE_REPLY_EN
    check("rst_reply_any", 512'(bus10.reply_any), 512'(0));
    check("rst_reply_all", 512'(bus10.reply_all), 512'(0));
`endif
    #10;
    reset = 1'b0;

    // T1: single message, visible for one cycle after edge k+2.
    bus10.in_valid = 1'b1; bus10.in_message = 16'hBEEF;
    tick();
    bus10.in_valid = 1'b0;
    check("t1_e0_valids", 512'(bus10.out_valids), 512'(0));
    tick();
    check("t1_e1_valids", 512'(bus10.out_valids), 512'(0));
    tick();
    check("t1_e2_valids", 512'(bus10.out_valids), 512'(10'h3FF));
    check("t1_e2_data", 512'(bus10.outputs), rep(16'hBEEF, 10));
    tick();
    check("t1_e3_valids", 512'(bus10.out_valids), 512'(0));
    check("t1_e3_hold", 512'(bus10.outputs), rep(16'hBEEF, 10));

    // T2: messages 1..20 back to back; message m appears after edge m+1.
    for (int t = 0; t <= 22; t++) begin
      bus10.in_valid   = (t < 20);
      bus10.in_message = 16'(t + 1);
      tick();
      if (t >= 2 && t <= 21) begin
        check($sformatf("t2_valids_%0d", t), 512'(bus10.out_valids), 512'(10'h3FF));
        check($sformatf("t2_data_%0d", t), 512'(bus10.outputs), rep(16'(t - 1), 10));
      end else begin
        check($sformatf("t2_idle_%0d", t), 512'(bus10.out_valids), 512'(0));
      end
    end

    // T4: A, B, C on edges 0..2 with clear at edge 1; only C arrives (edge 4).
    msg_a = 16'h00A1; msg_b = 16'h00B2; msg_c = 16'h00C3;
    for (int e = 0; e <= 6; e++) begin
      bus10.in_valid   = (e <= 2);
      bus10.in_message = (e == 0) ? msg_a : (e == 1) ? msg_b : msg_c;
      bus10.clear      = (e == 1);
      tick();
      check($sformatf("t4_valids_%0d", e), 512'(bus10.out_valids),
            (e == 4) ? 512'(10'h3FF) : 512'(0));
      check($sformatf("t4_data_%0d", e), 512'(bus10.outputs),
            (e >= 4) ? rep(msg_c, 10) : rep(16'd20, 10));
    end
    bus10.clear = 1'b0;

    // T5: three messages in flight, asynchronous reset between edges.
    for (int e = 0; e <= 2; e++) begin
      bus10.in_valid   = 1'b1;
      bus10.in_message = 16'hD000 + 16'(e);
      tick();
    end
    bus10.in_valid = 1'b0;
    check("t5_pre_valids", 512'(bus10.out_valids), 512'(10'h3FF));
    check("t5_pre_data", 512'(bus10.outputs), rep(16'hD000, 10));
    #3 reset = 1'b1;
    #1;
    check("t5_rst_valids", 512'(bus10.out_valids), 512'(0));
    check("t5_rst_data", 512'(bus10.outputs), 512'(0));
    #1 reset = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      check($sformatf("t5_post_valids_%0d", e), 512'(bus10.out_valids), 512'(0));
      check($sformatf("t5_post_data_%0d", e), 512'(bus10.outputs), 512'(0));
    end

`ifdef PIPELINED_BROADCAST_TREE_REPLY_EN
    // T6: replies 3FF, 001, 000 on edges 0..2 -> 1/1, 1/0, 0/0 after edges 2..4.
    // clear is pulsed on edge 1 and must not disturb the reduction.
    bus10.node_replies = 10'h3FF;
    tick();
    bus10.node_replies = 10'h001;
    bus10.clear = 1'b1;
    tick();
    bus10.clear = 1'b0;
    check("t6_e1_any", 512'(bus10.reply_any), 512'(0));
    check("t6_e1_all", 512'(bus10.reply_all), 512'(0));
    bus10.node_replies = 10'h000;
    tick();
    check("t6_e2_any", 512'(bus10.reply_any), 512'(1));
    check("t6_e2_all", 512'(bus10.reply_all), 512'(1));
    tick();
    check("t6_e3_any", 512'(bus10.reply_any), 512'(1));
    check("t6_e3_all", 512'(bus10.reply_all), 512'(0));
    tick();
    check("t6_e4_any", 512'(bus10.reply_any), 512'(0));
    check("t6_e4_all", 512'(bus10.reply_all), 512'(0));
`endif

    // T3: depth boundaries. Latency 1, 2, 3, 4 for N = 1, 9, 27, 28,
    // i.e. first visible after edge 0, 1, 2, 3.
    for (int d = 0; d < 4; d++) begin
      first[d] = -1;
      hits[d]  = 0;
      seen[d]  = '0;
    end
    bus1.in_valid  = 1'b1; bus1.in_message  = 16'h1001;
    bus9.in_valid  = 1'b1; bus9.in_message  = 16'h1009;
    bus27.in_valid = 1'b1; bus27.in_message = 16'h1027;
    bus28.in_valid = 1'b1; bus28.in_message = 16'h1028;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (e == 0) begin
        bus1.in_valid = 1'b0; bus9.in_valid = 1'b0;
        bus27.in_valid = 1'b0; bus28.in_valid = 1'b0;
      end
      if (&bus1.out_valids) begin
        hits[0]++;
        if (first[0] < 0) begin first[0] = e; seen[0] = 512'(bus1.outputs); end
      end
      if (&bus9.out_valids) begin
        hits[1]++;
        if (first[1] < 0) begin first[1] = e; seen[1] = 512'(bus9.outputs); end
      end
      if (&bus27.out_valids) begin
        hits[2]++;
        if (first[2] < 0) begin first[2] = e; seen[2] = 512'(bus27.outputs); end
      end
      if (&bus28.out_valids) begin
        hits[3]++;
        if (first[3] < 0) begin first[3] = e; seen[3] = 512'(bus28.outputs); end
      end
    end
    check("t3_n1_edge",  512'(first[0]), 512'(0));
    check("t3_n1_data",  seen[0], rep(16'h1001, 1));
    check("t3_n1_once",  512'(hits[0]), 512'(1));
    check("t3_n9_edge",  512'(first[1]), 512'(1));
    check("t3_n9_data",  seen[1], rep(16'h1009, 9));
    check("t3_n9_once",  512'(hits[1]), 512'(1));
    check("t3_n27_edge", 512'(first[2]), 512'(2));
    check("t3_n27_data", seen[2], rep(16'h1027, 27));
    check("t3_n27_once", 512'(hits[2]), 512'(1));
    check("t3_n28_edge", 512'(first[3]), 512'(3));
    check("t3_n28_data", seen[3], rep(16'h1028, 28));
    check("t3_n28_once", 512'(hits[3]), 512'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
